// File: rtl/spi_xfer16_pkg.sv
// Shared definitions for the spi_xfer16 SPI master.
//   - state_e      : controller states (idle, shifting, back porch)
//   - Div32*       : 5-bit divider constants (SCLK = clk/32)
//   - Div16*       : 4-bit divider constants (SCLK = clk/16)
//   - BitLimit     : number of bits per transaction
package spi_xfer16_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StBack
  } state_e;

  // clk/32 divider: SCLK is the divider MSB.
  localparam int unsigned Div32W      = 5;
  localparam logic [4:0]  Div32Reload = 5'b10111;
  localparam logic [4:0]  Div32Sample = 5'b01111;
  localparam logic [4:0]  Div32Shift  = 5'b11111;

  // clk/16 divider: SCLK is the divider MSB.
  localparam int unsigned Div16W      = 4;
  localparam logic [3:0]  Div16Reload = 4'b1011;
  localparam logic [3:0]  Div16Sample = 4'b0111;
  localparam logic [3:0]  Div16Shift  = 4'b1111;

  localparam int unsigned      BitCntW  = 5;
  localparam logic [BitCntW-1:0] BitLimit = 5'd16;

endpackage

// File: rtl/spi_xfer16.sv
// spi_xfer16: 16-bit SPI master, mode 3 (CPOL=1, CPHA=1), single clock domain.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   snd    in   one-clock start strobe, accepted only while idle
//   cmd    in   16-bit word to transmit MSB first, sampled when snd is accepted
//   done   out  transaction complete; held until the next accepted snd
//   resp   out  16-bit word received on MISO (shift-register contents)
//   SS_n   out  active-low serf select, low for the whole transaction
//   SCLK   out  serial clock, idles high (divider MSB)
//   MOSI   out  serial data out (shift-register bit 15)
//   MISO   in   serial data in
//
// Configuration:
//   SPI_SCLK_DIV16_EN  defined   -> 4-bit divider, SCLK = clk/16
//                      undefined -> 5-bit divider, SCLK = clk/32
module spi_xfer16
  import spi_xfer16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] resp,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

`ifdef SPI_SCLK_DIV16_EN
  localparam int unsigned     DivW      = Div16W;
  localparam logic [DivW-1:0] DivReload = Div16Reload;
  localparam logic [DivW-1:0] DivSample = Div16Sample;
  localparam logic [DivW-1:0] DivShift  = Div16Shift;
`else
  localparam int unsigned     DivW      = Div32W;
  localparam logic [DivW-1:0] DivReload = Div32Reload;
  localparam logic [DivW-1:0] DivSample = Div32Sample;
  localparam logic [DivW-1:0] DivShift  = Div32Shift;
`endif

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [15:0]          shreg_q, shreg_d;
  logic                 sample_q, sample_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;
  logic                 ss_n_q, ss_n_d;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sample_d  = sample_q;
    pend_d    = pend_q;
    done_d    = done_q;
    ss_n_d    = ss_n_q;

    unique case (state_q)
      StIdle: begin
        // Divider parked so SCLK sits high and the first fall comes a few
        // clocks after SS_n drops.
        div_d = DivReload;
        if (snd) begin
          shreg_d   = cmd;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
          done_d    = 1'b0;
          ss_n_d    = 1'b0;
          state_d   = StShift;
        end
      end

      StShift: begin
        if (bit_cnt_q == BitLimit) begin
          // All bits shifted; divider already parked high, so no trailing fall.
          state_d = StBack;
        end else begin
          div_d = div_q + 1'b1;
          // Capture MISO on the clock just before SCLK rises.
          if (div_q == DivSample) begin
            sample_d = MISO;
            pend_d   = 1'b1;
          end
          // Shift as SCLK falls; the leading fall has no pending sample and
          // leaves the register alone.
          if ((div_q == DivShift) && pend_q) begin
            shreg_d   = {shreg_q[14:0], sample_q};
            bit_cnt_d = bit_cnt_q + 1'b1;
            pend_d    = 1'b0;
            if (bit_cnt_q == BitLimit - 1'b1) begin
              div_d = DivReload;
            end
          end
        end
      end

      StBack: begin
        ss_n_d  = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DivReload;
    end else begin
      div_q <= div_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= 16'h0000;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
    end else begin
      sample_q <= sample_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q <= 1'b1;
    end else begin
      ss_n_q <= ss_n_d;
    end
  end

  assign done = done_q;
  assign resp = shreg_q;
  assign SS_n = ss_n_q;
  assign SCLK = div_q[DivW-1];
  assign MOSI = shreg_q[15];

endmodule

// File: tb/tb_spi_xfer16.sv
// Directed self-checking bench for spi_xfer16 with a mode-3 serf model.
module tb_spi_xfer16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO = 1'b0;

`ifdef SPI_SCLK_DIV16_EN
  localparam int          DoneEdge   = 263;
  localparam int          IgnoreEdge = 100;
  localparam int          ResetEdge  = 150;
  localparam logic [15:0] MainCmd    = 16'hA65A;
  localparam logic [15:0] MainResp   = 16'h0123;
`else
  localparam int          DoneEdge   = 523;
  localparam int          IgnoreEdge = 200;
  localparam int          ResetEdge  = 300;
  localparam logic [15:0] MainCmd    = 16'h0D02;
  localparam logic [15:0] MainResp   = 16'hA5C3;
`endif

  spi_xfer16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .snd  (snd),
    .cmd  (cmd),
    .done (done),
    .resp (resp),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Serf model: drives the next response bit on every SCLK fall while selected.
  logic [15:0] serf_word = 16'h0000;
  int          serf_idx  = 0;
  always @(negedge SCLK or posedge SS_n) begin
    if (SS_n) begin
      serf_idx = 0;
    end else if (serf_idx < 16) begin
      MISO = serf_word[15 - serf_idx];
      serf_idx++;
    end
  end

  // Bits seen on MOSI at each SCLK rise while selected.
  logic [15:0] mosi_bits = 16'h0000;
  int          rise_cnt  = 0;
  always @(posedge SCLK) begin
    if (SS_n === 1'b0) begin
      mosi_bits = {mosi_bits[14:0], MOSI};
      rise_cnt++;
    end
  end

  int done_rises = 0;
  always @(posedge done) done_rises++;

  int sclk_viol = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && SS_n === 1'b1 && SCLK !== 1'b1) sclk_viol++;
  end

  int rise_base;
  int done_base;

  // Called #1 after a posedge; snd is accepted at the next edge (edge 0).
  task automatic start_xfer(input logic [15:0] c, input logic [15:0] w);
    serf_word = w;
    rise_base = rise_cnt;
    done_base = done_rises;
    snd = 1'b1;
    cmd = c;
    @(posedge clk);
    #1;
    snd = 1'b0;
    cmd = ~c;
  endtask

  // Returns the edge index (relative to the accept edge) where done was first seen.
  task automatic wait_done(output int e);
    e = -1;
    for (int i = 1; i <= DoneEdge + 100; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        e = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    snd   = 1'b0;
    cmd   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (SS_n !== 1'b1) $display("FAIL reset_ss_n: got %b want 1", SS_n); else n_pass++;
    n_checks++; if (SCLK !== 1'b1) $display("FAIL reset_sclk: got %b want 1", SCLK); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (resp !== 16'h0000) $display("FAIL reset_resp: got %h want 0000", resp);
    else n_pass++;
    n_checks++; if (MOSI !== 1'b0) $display("FAIL reset_mosi: got %b want 0", MOSI); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (SS_n !== 1'b1) $display("FAIL idle_ss_n: got %b want 1", SS_n); else n_pass++;
    n_checks++; if (SCLK !== 1'b1) $display("FAIL idle_sclk: got %b want 1", SCLK); else n_pass++;
  endtask

  task automatic test_basic();
    int e;
    start_xfer(MainCmd, MainResp);
    n_checks++; if (SS_n !== 1'b0) $display("FAIL basic_ss_low: got %b want 0", SS_n);
    else n_pass++;
    wait_done(e);
    n_checks++; if (e != DoneEdge) $display("FAIL basic_done_edge: got %0d want %0d", e, DoneEdge);
    else n_pass++;
    n_checks++; if (mosi_bits !== MainCmd)
      $display("FAIL basic_mosi: got %h want %h", mosi_bits, MainCmd);
    else n_pass++;
    n_checks++; if (resp !== MainResp) $display("FAIL basic_resp: got %h want %h", resp, MainResp);
    else n_pass++;
    n_checks++; if (rise_cnt - rise_base != 16)
      $display("FAIL basic_rises: got %0d want 16", rise_cnt - rise_base);
    else n_pass++;
    n_checks++; if (SS_n !== 1'b1) $display("FAIL basic_ss_high: got %b want 1", SS_n);
    else n_pass++;
  endtask

  // Re-pulse snd mid-transfer and again on the BACK-to-IDLE clock.
  task automatic test_ignore();
    int e;
    e = -1;
    start_xfer(MainCmd, 16'h5AA5);
    for (int i = 1; i <= DoneEdge + 100; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && e < 0) e = i;
      if (i == IgnoreEdge - 1) begin
        snd = 1'b1;
        cmd = 16'hFFFF;
      end
      if (i == IgnoreEdge) snd = 1'b0;
      if (i == DoneEdge - 1) snd = 1'b1;
      if (i == DoneEdge) snd = 1'b0;
    end
    n_checks++; if (e != DoneEdge) $display("FAIL ign_done_edge: got %0d want %0d", e, DoneEdge);
    else n_pass++;
    n_checks++; if (mosi_bits !== MainCmd)
      $display("FAIL ign_mosi: got %h want %h", mosi_bits, MainCmd);
    else n_pass++;
    n_checks++; if (resp !== 16'h5AA5) $display("FAIL ign_resp: got %h want 5aa5", resp);
    else n_pass++;
    n_checks++; if (done_rises - done_base != 1)
      $display("FAIL ign_done_count: got %0d want 1", done_rises - done_base);
    else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL ign_done_held: got %b want 1", done);
    else n_pass++;
    n_checks++; if (SS_n !== 1'b1) $display("FAIL ign_ss_n: got %b want 1", SS_n); else n_pass++;
    n_checks++; if (rise_cnt - rise_base != 16)
      $display("FAIL ign_rises: got %0d want 16", rise_cnt - rise_base);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int e;
    start_xfer(MainCmd, MainResp);
    repeat (ResetEdge) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (SS_n !== 1'b1) $display("FAIL rmid_ss_n: got %b want 1", SS_n); else n_pass++;
    n_checks++; if (SCLK !== 1'b1) $display("FAIL rmid_sclk: got %b want 1", SCLK); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rmid_done: got %b want 0", done); else n_pass++;
    n_checks++; if (resp !== 16'h0000) $display("FAIL rmid_resp: got %h want 0000", resp);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_xfer(16'h1160, 16'h3C5A);
    wait_done(e);
    n_checks++; if (e != DoneEdge) $display("FAIL rmid_done_edge: got %0d want %0d", e, DoneEdge);
    else n_pass++;
    n_checks++; if (mosi_bits !== 16'h1160) $display("FAIL rmid_mosi: got %h want 1160", mosi_bits);
    else n_pass++;
    n_checks++; if (resp !== 16'h3C5A) $display("FAIL rmid_resp2: got %h want 3c5a", resp);
    else n_pass++;
    n_checks++; if (done_rises - done_base != 1)
      $display("FAIL rmid_done_count: got %0d want 1", done_rises - done_base);
    else n_pass++;
    n_checks++; if (rise_cnt - rise_base != 16)
      $display("FAIL rmid_rises: got %0d want 16", rise_cnt - rise_base);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e;
    start_xfer(16'h1160, 16'hC001);
    wait_done(e);
    n_checks++; if (e != DoneEdge) $display("FAIL b2b_done_edge1: got %0d want %0d", e, DoneEdge);
    else n_pass++;
    n_checks++; if (mosi_bits !== 16'h1160) $display("FAIL b2b_mosi1: got %h want 1160", mosi_bits);
    else n_pass++;
    n_checks++; if (resp !== 16'hC001) $display("FAIL b2b_resp1: got %h want c001", resp);
    else n_pass++;
    // First idle clock after done rose: new snd must be accepted.
    start_xfer(16'h1440, 16'h8421);
    n_checks++; if (done !== 1'b0) $display("FAIL b2b_done_drop: got %b want 0", done);
    else n_pass++;
    n_checks++; if (SS_n !== 1'b0) $display("FAIL b2b_ss_low: got %b want 0", SS_n); else n_pass++;
    wait_done(e);
    n_checks++; if (e != DoneEdge) $display("FAIL b2b_done_edge2: got %0d want %0d", e, DoneEdge);
    else n_pass++;
    n_checks++; if (mosi_bits !== 16'h1440) $display("FAIL b2b_mosi2: got %h want 1440", mosi_bits);
    else n_pass++;
    n_checks++; if (resp !== 16'h8421) $display("FAIL b2b_resp2: got %h want 8421", resp);
    else n_pass++;
    n_checks++; if (done_rises - done_base != 1)
      $display("FAIL b2b_done_count: got %0d want 1", done_rises - done_base);
    else n_pass++;
  endtask

  task automatic test_sclk_idle();
    n_checks++; if (sclk_viol != 0)
      $display("FAIL sclk_idle_high: got %0d low samples want 0", sclk_viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_sclk_idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
